seq_engine_arbiter: RTL and testbench

- Shares one pa2_fsm sequence-match engine (valid/num/seq in, hit out) among NUM_REQ requesters using round-robin grants.
- Forwards the granted requester's sequence to the engine and keeps a shadow match count.
- Holds the grant through the engine's hit burst, then through one idle gap, so bursts never overlap.
- Routes the engine's hit back to the owning requester.

---
 rtl/seq_arb_pkg.sv | 17 +
 rtl/seq_engine_arbiter_rr_picker.sv | 29 ++
 rtl/seq_engine_arbiter.sv | 159 +++++++++++++++
 tb/tb_seq_engine_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_arb_pkg.sv
// Shared types and default sizing for the sequence-engine arbiter.
// The arbiter's optional hit checker is enabled by defining SEQ_ARB_HIT_CHECK_EN.
package seq_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANT,
      ARB_DRAIN,
      ARB_GAP
   } arb_state_t;

   localparam int NUM_REQ_DEF = 4;
   localparam int CNT_W_DEF   = 4;
   localparam int MAX_LEN_DEF = 10;
   localparam int SEQ_W       = 4;

endpackage

// File: rtl/seq_engine_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic [IDX_W-1:0]   pick_idx,
   output logic               any
);

   // Walk offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      int idx;
      idx      = 0;
      pick_idx = '0;
      any      = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (req[idx]) begin
            pick_idx = IDX_W'(idx);
            any      = 1'b1;
         end
      end
      pick = any ? (NUM_REQ'(1) << pick_idx) : '0;
   end

endmodule

// File: rtl/seq_engine_arbiter.sv
// Round-robin sharing of one sequence-match engine among NUM_REQ requesters.
// Define SEQ_ARB_HIT_CHECK_EN to add the sticky hit_err protocol checker.
module seq_engine_arbiter
   import seq_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [SEQ_W-1:0]               cfg_num,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ-1:0][SEQ_W-1:0]  req_seq,
   output logic [NUM_REQ-1:0]             gnt,
   output logic                           eng_valid,
   output logic [SEQ_W-1:0]               eng_num,
   output logic [SEQ_W-1:0]               eng_seq,
   input  logic                           eng_hit,
   output logic [NUM_REQ-1:0]             hit_out,
   output logic                           busy
`ifdef SEQ_ARB_HIT_CHECK_EN
   ,output logic                          hit_err
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_t         state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [NUM_REQ-1:0] owner_oh_q, owner_oh_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic [CNT_W-1:0]   match_q, match_d;
   logic [CNT_W-1:0]   drain_q, drain_d;

   logic [NUM_REQ-1:0] pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic               owner_req;
   logic [SEQ_W-1:0]   owner_seq;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req      (req),
      .rr_ptr   (rr_ptr_q),
      .pick     (pick_oh),
      .pick_idx (pick_idx),
      .any      (pick_any)
   );

   assign owner_req = req[owner_q];
   assign owner_seq = req_seq[owner_q];
   assign eng_num   = cfg_num;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      owner_oh_d = owner_oh_q;
      len_d      = len_q;
      match_d    = match_q;
      drain_d    = drain_q;
      gnt        = '0;
      eng_valid  = 1'b0;
      eng_seq    = '0;
      hit_out    = '0;
      busy       = (state_q != ARB_IDLE);

      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               owner_d    = pick_idx;
               owner_oh_d = pick_oh;
               rr_ptr_d   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
               len_d      = '0;
               match_d    = '0;
               state_d    = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            gnt = owner_oh_q;
            if (owner_req) begin
               eng_valid = 1'b1;
               eng_seq   = owner_seq;
               len_d     = len_q + 1'b1;
               if (owner_seq == cfg_num && match_q != '1)
                  match_d = match_q + 1'b1;
            end
            // The drain count must include the element accepted on the exit cycle.
            if (!owner_req || len_d == CNT_W'(MAX_LEN)) begin
               drain_d = match_d;
               state_d = ARB_DRAIN;
            end
         end
         ARB_DRAIN: begin
            gnt     = owner_oh_q;
            hit_out = eng_hit ? owner_oh_q : '0;
            if (drain_q != '0)
               drain_d = drain_q - 1'b1;
            if (drain_q <= CNT_W'(1))
               state_d = ARB_GAP;
         end
         ARB_GAP: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ARB_IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         owner_oh_q <= '0;
         len_q      <= '0;
         match_q    <= '0;
         drain_q    <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         owner_oh_q <= owner_oh_d;
         len_q      <= len_d;
         match_q    <= match_d;
         drain_q    <= drain_d;
      end
   end

`ifdef SEQ_ARB_HIT_CHECK_EN
   logic hit_err_q, hit_err_d;

   // Engine hit is only legal during the first drain_q cycles of DRAIN.
   always_comb begin
      hit_err_d = hit_err_q;
      case (state_q)
         ARB_IDLE:  if (eng_hit) hit_err_d = 1'b1;
         ARB_DRAIN: if (eng_hit != (drain_q != '0)) hit_err_d = 1'b1;
         ARB_GAP:   if (eng_hit) hit_err_d = 1'b1;
         default:   hit_err_d = hit_err_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset)
         hit_err_q <= 1'b0;
      else
         hit_err_q <= hit_err_d;
   end

   assign hit_err = hit_err_q;
`endif

endmodule

// File: tb/tb_seq_engine_arbiter.sv
// Directed self-checking bench for seq_engine_arbiter (default 4 requesters, MAX_LEN 10).
// Exercises hit_err as well when SEQ_ARB_HIT_CHECK_EN is defined.
module tb_seq_engine_arbiter;

   logic             clock = 1'b0;
   logic             reset;
   logic [3:0]       cfg_num;
   logic [3:0]       req;
   logic [3:0][3:0]  req_seq;
   logic [3:0]       gnt;
   logic             eng_valid;
   logic [3:0]       eng_num;
   logic [3:0]       eng_seq;
   logic             eng_hit;
   logic [3:0]       hit_out;
   logic             busy;
`ifdef SEQ_ARB_HIT_CHECK_EN
   logic             hit_err;
`endif

   int compared   = 0;
   int mismatched = 0;

   seq_engine_arbiter dut (
      .clock     (clock),
      .reset     (reset),
      .cfg_num   (cfg_num),
      .req       (req),
      .req_seq   (req_seq),
      .gnt       (gnt),
      .eng_valid (eng_valid),
      .eng_num   (eng_num),
      .eng_seq   (eng_seq),
      .eng_hit   (eng_hit),
      .hit_out   (hit_out),
      .busy      (busy)
`ifdef SEQ_ARB_HIT_CHECK_EN
      ,.hit_err  (hit_err)
`endif
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkCycle(input string tag, input logic [3:0] exp_gnt, input logic exp_valid,
                             input logic [3:0] exp_seq, input logic [3:0] exp_hit, input logic exp_busy);
      checkOutput({tag, "_gnt"},   32'(gnt),       32'(exp_gnt));
      checkOutput({tag, "_valid"}, 32'(eng_valid), 32'(exp_valid));
      checkOutput({tag, "_seq"},   32'(eng_seq),   32'(exp_seq));
      checkOutput({tag, "_hit"},   32'(hit_out),   32'(exp_hit));
      checkOutput({tag, "_busy"},  32'(busy),      32'(exp_busy));
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
   task automatic applyStimulus(input logic [3:0] r, input logic [15:0] s, input logic h);
      req     = r;
      req_seq = s;
      eng_hit = h;
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   function automatic bit inRange(input int c, input int lo, input int hi);
      return (c >= lo) && (c <= hi);
   endfunction

   initial begin
      logic [3:0] eg;
      logic       ev;
      logic [3:0] es;
      logic [3:0] eh;
      logic       eb;
      int         busyCnt;

      reset   = 1'b1;
      cfg_num = 4'd7;
      applyStimulus(4'b0000, 16'h0000, 1'b0);
      nextCycle();
      nextCycle();
      checkCycle("rst", 4'b0000, 1'b0, 4'h0, 4'b0000, 1'b0);
      checkOutput("rst_num", 32'(eng_num), 32'd7);
      reset   = 1'b0;
      cfg_num = 4'd5;

      // Requester 1 sends four matching elements, then drops its request.
      for (int c = 0; c < 12; c++) begin
         applyStimulus((c <= 4) ? 4'b0010 : 4'b0000, 16'h5555, 1'b1);
         eg = inRange(c, 1, 9)  ? 4'b0010 : 4'b0000;
         ev = inRange(c, 1, 4);
         es = ev ? 4'h5 : 4'h0;
         eh = inRange(c, 6, 9)  ? 4'b0010 : 4'b0000;
         eb = inRange(c, 1, 10);
         checkCycle($sformatf("t1c%0d", c), eg, ev, es, eh, eb);
         nextCycle();
      end

      // Requester 2 sends ten non-matching elements; the length cap ends GRANT.
      busyCnt = 0;
      for (int c = 0; c < 14; c++) begin
         applyStimulus((c <= 10) ? 4'b0100 : 4'b0000, 16'h3333, 1'b0);
         if (busy) busyCnt++;
         eg = inRange(c, 1, 11) ? 4'b0100 : 4'b0000;
         ev = inRange(c, 1, 10);
         es = ev ? 4'h3 : 4'h0;
         eb = inRange(c, 1, 12);
         checkCycle($sformatf("t2c%0d", c), eg, ev, es, 4'b0000, eb);
         nextCycle();
      end
      checkOutput("t2_busy_cycles", 32'(busyCnt), 32'd12);

      // Requester 0 holds req through the cap, re-wins, then withdraws on the first GRANT cycle.
      for (int c = 0; c < 27; c++) begin
         applyStimulus((c <= 22) ? 4'b0001 : 4'b0000, 16'h5555, (c <= 22));
         eg = (inRange(c, 1, 20) || inRange(c, 23, 24)) ? 4'b0001 : 4'b0000;
         ev = inRange(c, 1, 10);
         es = ev ? 4'h5 : 4'h0;
         eh = inRange(c, 11, 20) ? 4'b0001 : 4'b0000;
         eb = inRange(c, 1, 21) || inRange(c, 23, 25);
         checkCycle($sformatf("t3c%0d", c), eg, ev, es, eh, eb);
         nextCycle();
      end

      // Requesters 0 and 3 both held from reset: grants alternate 0, 3, 0, 3.
      reset = 1'b1;
      applyStimulus(4'b1001, 16'h2005, 1'b1);
      nextCycle();
      reset = 1'b0;
      for (int c = 0; c < 61; c++) begin
         applyStimulus(4'b1001, 16'h2005, 1'b1);
         if (inRange(c, 1, 20) || inRange(c, 36, 55))
            eg = 4'b0001;
         else if (inRange(c, 23, 33) || inRange(c, 58, 60))
            eg = 4'b1000;
         else
            eg = 4'b0000;
         ev = inRange(c, 1, 10) || inRange(c, 23, 32) || inRange(c, 36, 45) || inRange(c, 58, 60);
         es = !ev ? 4'h0 : (eg == 4'b0001) ? 4'h5 : 4'h2;
         if (inRange(c, 11, 20) || inRange(c, 46, 55))
            eh = 4'b0001;
         else if (c == 33)
            eh = 4'b1000;
         else
            eh = 4'b0000;
         eb = (eg != 4'b0000) || c == 21 || c == 34 || c == 56;
         checkCycle($sformatf("t4c%0d", c), eg, ev, es, eh, eb);
         nextCycle();
      end

      // Reset in the third GRANT cycle aborts and returns rr_ptr to 0.
      reset = 1'b1;
      applyStimulus(4'b0000, 16'h5555, 1'b0);
      nextCycle();
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) reset = 1'b1;
         applyStimulus(4'b0010, 16'h5555, 1'b0);
         eg = (c >= 1) ? 4'b0010 : 4'b0000;
         checkCycle($sformatf("t5c%0d", c), eg, (c >= 1), (c >= 1) ? 4'h5 : 4'h0, 4'b0000, (c >= 1));
         nextCycle();
      end
      reset = 1'b0;
      applyStimulus(4'b1010, 16'h5555, 1'b0);
      checkCycle("t5_after_rst", 4'b0000, 1'b0, 4'h0, 4'b0000, 1'b0);
      checkOutput("t5_num", 32'(eng_num), 32'd5);
      nextCycle();
      applyStimulus(4'b0000, 16'h5555, 1'b0);
      checkOutput("t5_rr_restart", 32'(gnt), 32'b0010);
      nextCycle();

`ifdef SEQ_ARB_HIT_CHECK_EN
      reset = 1'b1;
      applyStimulus(4'b0000, 16'h0000, 1'b0);
      nextCycle();
      reset = 1'b0;
      checkOutput("t6_err_rst", 32'(hit_err), 32'd0);
      applyStimulus(4'b0000, 16'h0000, 1'b1);
      nextCycle();
      for (int c = 0; c < 3; c++) begin
         applyStimulus(4'b0000, 16'h0000, 1'b0);
         checkOutput($sformatf("t6_err_sticky%0d", c), 32'(hit_err), 32'd1);
         nextCycle();
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
